// File: rtl/ring_count_decoder.sv
// ring_count_decoder
// Receive-side monitor for a left-rotating one-hot ring counter. Each
// qualified sample is decoded to a binary index and checked against the
// previous one-hot sample rotated left by one. After LOCK_CNT consecutive
// legal steps the monitor declares lock. While locked it counts full
// revolutions (each MSB->LSB wrap) and flags any illegal step as an error.
//
// Ports:
//   Clock        rising-edge clock
//   Reset        asynchronous active-high reset
//   Ring_in      WIDTH-bit ring code sample (bit i set = position i)
//   Ring_valid   qualifies Ring_in on this edge
//   Err_clear    synchronous clear of Err_sticky (a same-edge error wins)
//   Index_out    binary position of the last valid one-hot sample
//   Index_valid  one-cycle pulse when Index_out was updated
//   Locked       high while the monitor is locked to the sequence
//   Err_pulse    one-cycle pulse on a sequence/code error while locked
//   Err_sticky   latched error flag
//   Rev_count    completed revolutions while locked, modulo 2^REV_W
//   Rev_wrap     one-cycle pulse when Rev_count rolls over to 0
module ring_count_decoder #(
  parameter int WIDTH    = 4,
  parameter int IDX_W    = 2,
  parameter int REV_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   Ring_in,
  input  logic               Ring_valid,
  input  logic               Err_clear,
  output logic [IDX_W-1:0]   Index_out,
  output logic               Index_valid,
  output logic               Locked,
  output logic               Err_pulse,
  output logic               Err_sticky,
  output logic [REV_W-1:0]   Rev_count,
  output logic               Rev_wrap
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // The step counter only ever needs to reach LOCK_CNT-1 before lock is
  // declared, so comparing against that value avoids an extra count bit.
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);

  logic [0:0]       state;
  logic [3:0]       step_cnt;
  logic [WIDTH-1:0] prev;
  logic             prev_ok;

  logic [CNT_W-1:0] ones;
  logic [IDX_W-1:0] pos;
  logic             one_hot;
  logic [WIDTH-1:0] expected;
  logic             step_ok;
  logic [REV_W-1:0] rev_next;

  // Population count and priority encode of the sample; pos is only
  // meaningful when exactly one bit is set.
  always_comb begin
    ones = '0;
    pos  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (Ring_in[i]) begin
        ones = ones + CNT_W'(1);
        pos  = IDX_W'(i);
      end
    end
  end

  assign one_hot  = (ones == CNT_W'(1));
  assign expected = {prev[WIDTH-2:0], prev[WIDTH-1]};
  assign step_ok  = prev_ok & one_hot & (Ring_in == expected);
  assign rev_next = Rev_count + REV_W'(1);
  assign Locked   = (state == ST_LOCKED);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= ST_HUNT;
      step_cnt    <= '0;
      prev        <= '0;
      prev_ok     <= 1'b0;
      Index_out   <= '0;
      Index_valid <= 1'b0;
      Err_pulse   <= 1'b0;
      Err_sticky  <= 1'b0;
      Rev_count   <= '0;
      Rev_wrap    <= 1'b0;
    end else begin
      Index_valid <= 1'b0;
      Err_pulse   <= 1'b0;
      Rev_wrap    <= 1'b0;

      // The error branch below assigns Err_sticky later, so a simultaneous
      // error overrides this clear.
      if (Err_clear) begin
        Err_sticky <= 1'b0;
      end

      if (Ring_valid) begin
        // A non-one-hot sample breaks the chain: the next one-hot sample
        // can only seed prev, never count as a legal step.
        if (one_hot) begin
          Index_out   <= pos;
          Index_valid <= 1'b1;
          prev        <= Ring_in;
          prev_ok     <= 1'b1;
        end else begin
          prev_ok <= 1'b0;
        end

        case (state)
          ST_HUNT: begin
            if (step_ok) begin
              if (step_cnt == LOCK_LAST) begin
                state    <= ST_LOCKED;
                step_cnt <= '0;
              end else begin
                step_cnt <= step_cnt + 4'd1;
              end
            end else begin
              step_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (step_ok) begin
              // Landing on bit 0 means the ring just wrapped from the MSB,
              // completing one revolution.
              if (Ring_in[0]) begin
                Rev_count <= rev_next;
                Rev_wrap  <= (rev_next == '0);
              end
            end else begin
              Err_pulse  <= 1'b1;
              Err_sticky <= 1'b1;
              state      <= ST_HUNT;
              step_cnt   <= '0;
            end
          end
          default: begin
            state    <= ST_HUNT;
            step_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_count_decoder.sv
// tb_ring_count_decoder
// Scoreboard bench for ring_count_decoder. The driver applies one sample
// per clock and pushes the reference model's expected outputs into a
// queue; an independent monitor pops and compares on each falling edge.
// The model tracks the ring as a position number and checks steps with
// modular arithmetic rather than bit rotation.
module tb_ring_count_decoder;

  localparam int WIDTH    = 4;
  localparam int IDX_W    = 2;
  localparam int REV_W    = 2;
  localparam int LOCK_CNT = 2;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic [WIDTH-1:0]  Ring_in = '0;
  logic              Ring_valid = 1'b0;
  logic              Err_clear = 1'b0;
  logic [IDX_W-1:0]  Index_out;
  logic              Index_valid;
  logic              Locked;
  logic              Err_pulse;
  logic              Err_sticky;
  logic [REV_W-1:0]  Rev_count;
  logic              Rev_wrap;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             iv;
    logic             lk;
    logic             ep;
    logic             es;
    logic [REV_W-1:0] rev;
    logic             rw;
  } exp_t;

  exp_t sbQueue[$];
  int   checks = 0;
  int   errors = 0;

  int mIdx, mPrevPos, mStreak, mRev;
  bit mHavePrev, mLocked, mSticky;

  ring_count_decoder #(
    .WIDTH(WIDTH), .IDX_W(IDX_W), .REV_W(REV_W), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Ring_in(Ring_in), .Ring_valid(Ring_valid),
    .Err_clear(Err_clear), .Index_out(Index_out), .Index_valid(Index_valid),
    .Locked(Locked), .Err_pulse(Err_pulse), .Err_sticky(Err_sticky),
    .Rev_count(Rev_count), .Rev_wrap(Rev_wrap)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mIdx = 0; mPrevPos = 0; mStreak = 0; mRev = 0;
    mHavePrev = 0; mLocked = 0; mSticky = 0;
  endtask

  // Reference behaviour for one clock edge.
  task automatic modelStep(input logic [WIDTH-1:0] ring, input logic valid, input logic clr);
    exp_t e;
    int   ones, pos;
    bit   legal, err;
    e = '0; ones = 0; pos = 0; legal = 0; err = 0;
    if (valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (ring[i]) begin
          ones++;
          pos = i;
        end
      end
      legal = mHavePrev && (ones == 1) && (pos == (mPrevPos + 1) % WIDTH);
      if (ones == 1) begin
        mIdx = pos;
        e.iv = 1'b1;
      end
      if (mLocked) begin
        if (legal) begin
          if (pos == 0) begin
            mRev = (mRev + 1) % (1 << REV_W);
            if (mRev == 0) e.rw = 1'b1;
          end
        end else begin
          err = 1; mLocked = 0; mStreak = 0;
        end
      end else if (legal) begin
        mStreak++;
        if (mStreak == LOCK_CNT) begin
          mLocked = 1; mStreak = 0;
        end
      end else begin
        mStreak = 0;
      end
      mHavePrev = (ones == 1);
      if (ones == 1) mPrevPos = pos;
    end
    if (clr) mSticky = 0;
    if (err) mSticky = 1;
    e.idx = IDX_W'(mIdx);
    e.lk  = mLocked;
    e.ep  = err;
    e.es  = mSticky;
    e.rev = REV_W'(mRev);
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] ring, input logic valid, input logic clr);
    Ring_in = ring; Ring_valid = valid; Err_clear = clr;
    @(posedge Clock);
    modelStep(ring, valid, clr);
    #1;
  endtask

  task automatic sendGap();
    applyStimulus(WIDTH'($urandom), 1'b0, 1'b0);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 10 && sbQueue.size() > 0; i++) begin
      @(negedge Clock);
      #1;
    end
    if (sbQueue.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbQueue.size());
      sbQueue.delete();
    end
  endtask

  // Asserts Reset between clock edges and checks the outputs clear at once.
  task automatic doReset();
    waitDrain();
    Reset = 1'b1;
    #1;
    checkOutput("rst_index_out", 32'(Index_out), 0);
    checkOutput("rst_index_valid", 32'(Index_valid), 0);
    checkOutput("rst_locked", 32'(Locked), 0);
    checkOutput("rst_err_pulse", 32'(Err_pulse), 0);
    checkOutput("rst_err_sticky", 32'(Err_sticky), 0);
    checkOutput("rst_rev_count", 32'(Rev_count), 0);
    checkOutput("rst_rev_wrap", 32'(Rev_wrap), 0);
    modelReset();
    #2;
    Reset = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] nextLegal();
    logic [WIDTH-1:0] one;
    one = WIDTH'(1);
    return one << (mHavePrev ? (mPrevPos + 1) % WIDTH : 0);
  endfunction

  // Monitor: compares each registered output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        checkOutput("index_out", 32'(Index_out), 32'(e.idx));
        checkOutput("index_valid", 32'(Index_valid), 32'(e.iv));
        checkOutput("locked", 32'(Locked), 32'(e.lk));
        checkOutput("err_pulse", 32'(Err_pulse), 32'(e.ep));
        checkOutput("err_sticky", 32'(Err_sticky), 32'(e.es));
        checkOutput("rev_count", 32'(Rev_count), 32'(e.rev));
        checkOutput("rev_wrap", 32'(Rev_wrap), 32'(e.rw));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    logic [WIDTH-1:0] rv;
    modelReset();
    #2;
    checkOutput("por_locked", 32'(Locked), 0);
    checkOutput("por_rev_count", 32'(Rev_count), 0);
    #5;
    Reset = 1'b0;

    $display("[TB] lock and first revolution");
    applyStimulus(4'b0001, 1, 0);
    applyStimulus(4'b0010, 1, 0);
    applyStimulus(4'b0100, 1, 0);
    applyStimulus(4'b1000, 1, 0);
    applyStimulus(4'b0001, 1, 0);

    $display("[TB] skip error, relock, sticky clear");
    applyStimulus(4'b0010, 1, 0);
    applyStimulus(4'b1000, 1, 0);
    applyStimulus(4'b0001, 1, 0);
    applyStimulus(4'b0010, 1, 0);
    applyStimulus(4'b0100, 1, 0);
    applyStimulus(4'b1000, 1, 1);
    applyStimulus(4'b0001, 1, 0);
    applyStimulus(4'b0001, 1, 1);

    $display("[TB] invalid code while locked");
    applyStimulus(4'b0010, 1, 0);
    applyStimulus(4'b0100, 1, 0);
    applyStimulus(4'b0011, 1, 0);
    applyStimulus(4'b0001, 1, 0);
    applyStimulus(4'b0010, 1, 0);
    applyStimulus(4'b0100, 1, 0);
    applyStimulus(4'b0000, 1, 0);

    $display("[TB] gaps and revolution wrap");
    doReset();
    applyStimulus(4'b0001, 1, 0); sendGap();
    applyStimulus(4'b0010, 1, 0); sendGap();
    applyStimulus(4'b0100, 1, 0); sendGap();
    for (int rev = 0; rev < 4; rev++) begin
      for (int p = 3; p < 7; p++) begin
        applyStimulus(WIDTH'(1) << (p % WIDTH), 1, 0);
        sendGap();
      end
    end
    applyStimulus(4'b1000, 1, 0);
    applyStimulus(4'b0001, 1, 0);
    doReset();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65) rv = nextLegal();
      else if (r < 85) rv = WIDTH'($urandom);
      else if (r < 92) rv = WIDTH'(1) << mPrevPos;
      else rv = WIDTH'(1) << ((mPrevPos + 2) % WIDTH);
      applyStimulus(rv, ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0);
      if (n == 200) doReset();
    end

    waitDrain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_count_decoder.md
Name: ring_count_decoder

Overview:
Receive-side companion to the team's one-hot ring counter. Samples a WIDTH-bit one-hot ring code and decodes it to a binary index. Checks that each qualified sample is the legal next step of the left-rotating ring sequence (0001->0010->0100->1000->0001). Tracks lock status, counts full revolutions and flags sequence errors. Sits downstream of any ring counter, typically on a different path or board region, as a sequence monitor/decoder.

Parameters:
WIDTH, 4, ring width in bits (>=2); one-hot code length.
IDX_W, 2, index width; must equal clog2(WIDTH).
REV_W, 8, revolution counter width.
LOCK_CNT, 2, consecutive legal steps required to declare lock (1..15).

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
Ring_in  input  WIDTH  ring code sample; bit i set = position i.
Ring_valid  input  1  qualifies Ring_in for this Clock edge.
Err_clear  input  1  synchronous clear of Err_sticky.
Index_out  output  IDX_W  binary position of last valid one-hot sample.
Index_valid  output  1  one-cycle pulse: Index_out updated this cycle.
Locked  output  1  high while FSM in LOCKED.
Err_pulse  output  1  one-cycle pulse on sequence/code error while locked.
Err_sticky  output  1  latched error flag.
Rev_count  output  REV_W  completed revolutions while locked, modulo 2^REV_W.
Rev_wrap  output  1  one-cycle pulse when Rev_count rolls from all-ones to 0.

Behaviour:
- Reset asserted (any time, asynchronously): all outputs 0, FSM=HUNT, step counter=0, prev register=0, prev_ok=0. Deasserted synchronously to Clock by the system.
- All outputs registered; a sample on edge N is reflected after edge N (1-cycle latency). Ring_valid=0: no state change, pulses deassert, Index_out/Rev_count hold.
- one_hot = exactly one bit of Ring_in set. expected = rotate-left(prev) (bit WIDTH-1 wraps to bit 0). step_ok = prev_ok & one_hot & (Ring_in == expected).
- Index_out/Index_valid: on valid one-hot sample, Index_out = bit position, Index_valid=1 next cycle. Non-one-hot sample: Index_out holds, Index_valid=0.
- prev: on valid one-hot sample prev<=Ring_in, prev_ok<=1; on valid non-one-hot sample prev_ok<=0.
- FSM HUNT: valid sample with step_ok -> step counter+1; counter reaching LOCK_CNT -> LOCKED, counter cleared. Valid sample without step_ok -> counter=0, stay HUNT. No errors and no Rev_count changes in HUNT.
- FSM LOCKED: valid sample with step_ok -> stay LOCKED; if Ring_in[0]=1 (MSB->LSB wrap) Rev_count+1, Rev_wrap pulses when result is 0. Valid sample without step_ok (skip, repeat, reverse step, zero, multi-hot) -> Err_pulse=1 for one cycle, Err_sticky<=1, FSM->HUNT, counter=0. Rev_count is not cleared on error (only by Reset).
- Err_clear=1 clears Err_sticky; if an error occurs on the same edge, set wins (Err_sticky=1).
- A repeated identical sample with Ring_valid=1 is a stall violation; upstream deasserts Ring_valid when the ring does not advance.
- Rev_count wraps modulo 2^REV_W silently apart from Rev_wrap.

Test Plan:
- Reset: assert Reset mid-cycle with Clock idle -> all outputs 0 immediately; Locked=0, Rev_count=0.
- Lock: WIDTH=4, LOCK_CNT=2, valid samples 0001,0010,0100 -> Index_out 0,1,2 with Index_valid pulses; Locked=1 after third edge; then 1000,0001 -> Rev_count=1 after the 0001 edge.
- Error: locked at 0010, send 1000 -> Err_pulse one cycle, Err_sticky=1, Locked=0, Index_out=3; then 0001,0010,0100 -> re-lock, Err_sticky stays 1 until Err_clear; Err_clear together with a new error -> Err_sticky=1.
- Invalid code: in LOCKED send 0011 -> Err_pulse, Locked=0, Index_out holds, Index_valid=0; next sample 0001 only seeds prev (counter stays 0).
- Gaps and wrap: REV_W=2, Ring_valid toggling 1/0 over 4 legal revolutions -> no errors, Rev_count 1,2,3,0 with Rev_wrap on the 0 transition; Reset mid-sequence -> HUNT, Rev_count=0.
